// File: rtl/geri_yaz_pkg.sv
// Shared write-back definitions: micro-op codes and fixed widths.
package geri_yaz_pkg;

    localparam int XLEN    = 32;
    localparam int RADR_W  = 5;
    localparam int MIKRO_W = 3;

    // Write-back micro-op codes; 3'b100..3'b111 are reserved and behave as GY_YOK.
    localparam logic [MIKRO_W-1:0] GY_YOK    = 3'b000;
    localparam logic [MIKRO_W-1:0] GY_SONUC  = 3'b001;
    localparam logic [MIKRO_W-1:0] GY_CARPMA = 3'b010;
    localparam logic [MIKRO_W-1:0] GY_PS     = 3'b011;

    // True for the three micro-ops that carry a register-file write.
    function automatic logic yazan_islem(input logic [MIKRO_W-1:0] mi);
        return (mi == GY_SONUC) || (mi == GY_CARPMA) || (mi == GY_PS);
    endfunction

endpackage

// File: rtl/geri_yaz_if.sv
// Execute-to-writeback inputs and register-file write port, bundled.
interface geri_yaz_if;
    import geri_yaz_pkg::*;

    logic [RADR_W-1:0]  yrt_rd_adres_i;
    logic [XLEN-1:0]    yrt_rd_deger_i;
    logic [MIKRO_W-1:0] yrt_mikroislem_i;
    logic [XLEN-1:0]    yrt_carpma_deger_i;
    logic [XLEN-2:0]    yrt_ps_artmis_i;

    logic [RADR_W-1:0]  cyo_yaz_adres_o;
    logic [XLEN-1:0]    cyo_yaz_deger_o;
    logic               cyo_yaz_yazmac_o;

    // The write-back stage itself.
    modport slave (
        input  yrt_rd_adres_i, yrt_rd_deger_i, yrt_mikroislem_i,
               yrt_carpma_deger_i, yrt_ps_artmis_i,
        output cyo_yaz_adres_o, cyo_yaz_deger_o, cyo_yaz_yazmac_o
    );

    // Whoever feeds the stage and consumes the write port.
    modport master (
        output yrt_rd_adres_i, yrt_rd_deger_i, yrt_mikroislem_i,
               yrt_carpma_deger_i, yrt_ps_artmis_i,
        input  cyo_yaz_adres_o, cyo_yaz_deger_o, cyo_yaz_yazmac_o
    );

endinterface

// File: rtl/geri_yaz_secici.sv
// Combinational source select for write-back: next data and write enable.
module geri_yaz_secici
    import geri_yaz_pkg::*;
(
    input  logic [MIKRO_W-1:0] mikroislem,
    input  logic [RADR_W-1:0]  rd_adres,
    input  logic [XLEN-1:0]    rd_deger,
    input  logic [XLEN-1:0]    carpma_deger,
    input  logic [XLEN-2:0]    ps_artmis,
    output logic [XLEN-1:0]    deger_d,
    output logic               yazmac_d
);

    // Pick the source; non-writing and reserved codes yield zero data.
    always_comb begin
        deger_d = '0;
        case (mikroislem)
            GY_SONUC:  deger_d = rd_deger;
            GY_CARPMA: deger_d = carpma_deger;
            GY_PS:     deger_d = {ps_artmis, 1'b0};
            default:   deger_d = '0;
        endcase
    end

    // x0 is hardwired zero, so writes to it are dropped while data still flows.
    assign yazmac_d = yazan_islem(mikroislem) && (rd_adres != '0);

endmodule

// File: rtl/geri_yaz.sv
// Write-back stage: registers the selected value onto the register-file port.
module geri_yaz
    import geri_yaz_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    geri_yaz_if.slave  bag
);

    logic [XLEN-1:0]   deger_d;
    logic              yazmac_d;

    logic [RADR_W-1:0] adres_q;
    logic [XLEN-1:0]   deger_q;
    logic              yazmac_q;

    geri_yaz_secici u_secici (
        .mikroislem   (bag.yrt_mikroislem_i),
        .rd_adres     (bag.yrt_rd_adres_i),
        .rd_deger     (bag.yrt_rd_deger_i),
        .carpma_deger (bag.yrt_carpma_deger_i),
        .ps_artmis    (bag.yrt_ps_artmis_i),
        .deger_d      (deger_d),
        .yazmac_d     (yazmac_d)
    );

    // One-cycle output register; reset wins and drops any in-flight write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            adres_q  <= '0;
            deger_q  <= '0;
            yazmac_q <= 1'b0;
        end else begin
            adres_q  <= bag.yrt_rd_adres_i;
            deger_q  <= deger_d;
            yazmac_q <= yazmac_d;
        end
    end

    assign bag.cyo_yaz_adres_o  = adres_q;
    assign bag.cyo_yaz_deger_o  = deger_q;
    assign bag.cyo_yaz_yazmac_o = yazmac_q;

endmodule

// File: tb/tb_geri_yaz.sv
// Directed bench for geri_yaz with a cycle-tagged scoreboard.
module tb_geri_yaz;
    import geri_yaz_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    geri_yaz_if bag ();

    geri_yaz dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bag    (bag)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       ad;
        logic [4:0]  adres;
        logic [31:0] deger;
        logic        yazmac;
        int          vade;
    } beklenen_t;

    beklenen_t sb[$];
    int cyc = 0;
    int n_test = 0;
    int n_fail = 0;

    always @(posedge clk_i) cyc++;

    // Drive one input set just after an edge; the next edge captures it.
    task automatic uygula(input string ad, input logic rst, input logic [4:0] adres,
                          input logic [2:0] mi, input logic [31:0] rd,
                          input logic [31:0] carp, input logic [30:0] ps,
                          input logic [4:0] e_adres, input logic [31:0] e_deger,
                          input logic e_yaz);
        beklenen_t b;
        @(posedge clk_i);
        #1;
        rst_ni                 = rst;
        bag.yrt_rd_adres_i     = adres;
        bag.yrt_mikroislem_i   = mi;
        bag.yrt_rd_deger_i     = rd;
        bag.yrt_carpma_deger_i = carp;
        bag.yrt_ps_artmis_i    = ps;
        b.ad = ad; b.adres = e_adres; b.deger = e_deger; b.yazmac = e_yaz;
        b.vade = cyc + 1;
        sb.push_back(b);
    endtask

    // Monitor: on each falling edge, check the entry due after the latest rising edge.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].vade <= cyc) begin
            beklenen_t b;
            b = sb.pop_front();
            n_test++;
            if (b.vade != cyc ||
                bag.cyo_yaz_adres_o  !== b.adres ||
                bag.cyo_yaz_deger_o  !== b.deger ||
                bag.cyo_yaz_yazmac_o !== b.yazmac) begin
                n_fail++;
                $display("FAIL %s: got adres=%h deger=%h yazmac=%b, want adres=%h deger=%h yazmac=%b",
                         b.ad, bag.cyo_yaz_adres_o, bag.cyo_yaz_deger_o, bag.cyo_yaz_yazmac_o,
                         b.adres, b.deger, b.yazmac);
            end
        end
    end

    localparam logic [31:0] RD = 32'h0000_FFFF;
    localparam logic [31:0] CP = 32'hFFFF_0000;
    localparam logic [30:0] PS = 31'h7FFF_FFFF;

    initial begin
        bag.yrt_rd_adres_i     = '0;
        bag.yrt_mikroislem_i   = '0;
        bag.yrt_rd_deger_i     = '0;
        bag.yrt_carpma_deger_i = '0;
        bag.yrt_ps_artmis_i    = '0;

        // Reset held with live-looking inputs.
        uygula("rst0", 1'b0, 5'd5, 3'b001, 32'h1234, 32'h5678, 31'h9, 5'h00, 32'h0, 1'b0);
        uygula("rst1", 1'b0, 5'd7, 3'b011, 32'hABCD, 32'h1111, 31'h3, 5'h00, 32'h0, 1'b0);

        // Source selection.
        uygula("sonuc",  1'b1, 5'd6, 3'b001, RD, CP, PS, 5'h06, 32'h0000_FFFF, 1'b1);
        uygula("carpma", 1'b1, 5'd6, 3'b010, RD, CP, PS, 5'h06, 32'hFFFF_0000, 1'b1);
        uygula("ps",     1'b1, 5'd6, 3'b011, RD, CP, PS, 5'h06, 32'hFFFF_FFFE, 1'b1);

        // No-write and reserved codes.
        uygula("yok",  1'b1, 5'd6, 3'b000, RD, CP, PS, 5'h06, 32'h0, 1'b0);
        uygula("r100", 1'b1, 5'd6, 3'b100, RD, CP, PS, 5'h06, 32'h0, 1'b0);
        uygula("r101", 1'b1, 5'd6, 3'b101, RD, CP, PS, 5'h06, 32'h0, 1'b0);
        uygula("r110", 1'b1, 5'd6, 3'b110, RD, CP, PS, 5'h06, 32'h0, 1'b0);
        uygula("r111", 1'b1, 5'd6, 3'b111, RD, CP, PS, 5'h06, 32'h0, 1'b0);

        // x0 suppression, then x1 writes.
        uygula("x0",    1'b1, 5'd0, 3'b001, RD, CP, PS, 5'h00, 32'h0000_FFFF, 1'b0);
        uygula("x1",    1'b1, 5'd1, 3'b001, RD, CP, PS, 5'h01, 32'h0000_FFFF, 1'b1);
        uygula("x0_ps", 1'b1, 5'd0, 3'b011, RD, CP, 31'h1234_5678, 5'h00, 32'h2468_ACF0, 1'b0);
        uygula("x31",   1'b1, 5'd31, 3'b001, 32'hDEAD_BEEF, CP, PS, 5'h1F, 32'hDEAD_BEEF, 1'b1);

        // Back-to-back changes, then reset mid-stream, then recovery.
        uygula("b2b_1",   1'b1, 5'd9, 3'b001, RD, CP, PS, 5'h09, 32'h0000_FFFF, 1'b1);
        uygula("b2b_2",   1'b1, 5'd9, 3'b010, RD, CP, PS, 5'h09, 32'hFFFF_0000, 1'b1);
        uygula("mid_rst", 1'b0, 5'd9, 3'b011, RD, CP, PS, 5'h00, 32'h0, 1'b0);
        uygula("recover", 1'b1, 5'd9, 3'b011, RD, CP, PS, 5'h09, 32'hFFFF_FFFE, 1'b1);
        uygula("b2b_3",   1'b1, 5'd3, 3'b000, RD, CP, PS, 5'h03, 32'h0, 1'b0);

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            n_test++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
